// File: rtl/trigger_event_recorder.sv
// -----------------------------------------------------------------------------
// trigger_event_recorder
//
// Consumer end of the coincidence trigger path. Each accepted rising edge of
// TRIGGER_IN is timestamped and stored as a 32-bit record in an on-chip FIFO:
//
//   record[31]    hit2   : SIGNAL2 seen in the last HIT_HIST samples
//   record[30]    hit1   : SIGNAL1 seen in the last HIT_HIST samples
//   record[29:24] lost   : edges dropped on a full FIFO since the last record
//   record[23:0]  ts     : free-running timestamp in the detection cycle
//
// The host drains the FIFO one byte per RD_REQ, most significant byte first.
// read_mode tells the trigger handler that an event readout is in progress.
//
// Optional feature macro: TRIGGER_RECORDER_DEADTIME_EN
//   defined     : after every capture (stored or dropped), rising edges in
//                 the next DEADTIME cycles are ignored.
//   not defined : no hold-off; every rising edge is captured or dropped.
//
// Ports
//   CLK          in   single clock
//   RESET        in   asynchronous, active-high; clears all control state
//   TRIGGER_IN   in   trigger from the coincidence handler
//   SIGNAL1      in   raw discriminator, channel 1
//   SIGNAL2      in   raw discriminator, channel 2
//   RD_REQ       in   host byte request (one-cycle pulse)
//   CLEAR_OVF    in   clears OVERFLOW (a same-cycle drop wins)
//   RD_DATA      out  readout byte, holds when RD_VALID is low
//   RD_VALID     out  one-cycle strobe qualifying RD_DATA
//   read_mode    out  high from the pop cycle through the byte-0 cycle
//   EVENT_COUNT  out  FIFO occupancy, 0..2^DEPTH_LOG2
//   OVERFLOW     out  sticky, set whenever an event is dropped
// -----------------------------------------------------------------------------
module trigger_event_recorder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DEADTIME   = 16,
    parameter int HIT_HIST   = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  TRIGGER_IN,
    input  logic                  SIGNAL1,
    input  logic                  SIGNAL2,
    input  logic                  RD_REQ,
    input  logic                  CLEAR_OVF,
    output logic [7:0]            RD_DATA,
    output logic                  RD_VALID,
    output logic                  read_mode,
    output logic [DEPTH_LOG2:0]   EVENT_COUNT,
    output logic                  OVERFLOW
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    if (DEADTIME < 1 || DEADTIME > 255) begin : g_bad_deadtime
        $error("trigger_event_recorder: DEADTIME must be in 1..255");
    end
    if (HIT_HIST < 1 || HIT_HIST > 8) begin : g_bad_hit_hist
        $error("trigger_event_recorder: HIT_HIST must be in 1..8");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_B3,
        S_B2,
        S_B1,
        S_B0
    } state_t;

    // timestamp and input history
    logic [23:0]           ts_q;
    logic                  trig_p1;
    logic [HIT_HIST-1:0]   hist1_q;
    logic [HIT_HIST-1:0]   hist2_q;
    logic [HIT_HIST-1:0]   hist1_n;
    logic [HIT_HIST-1:0]   hist2_n;
    logic                  hit1;
    logic                  hit2;

    // capture decision
    logic                  edge_det;
    logic                  capture;
    logic                  push;
    logic                  drop;
    logic [5:0]            lost_q;
    logic                  ovf_q;
    logic [31:0]           rec_in;

    // FIFO
    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  pop;

    // readout
    state_t                state_q;
    state_t                state_n;
    logic [31:0]           rec_q;
    logic [31:0]           rec_n;
    logic [7:0]            rd_data_n;
    logic                  rd_valid_n;
    logic                  read_mode_n;
    logic                  byte0_sent;

    // ---- stage p0: timestamp, trigger edge and channel history -------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ts_q    <= '0;
            trig_p1 <= 1'b0;
            hist1_q <= '0;
            hist2_q <= '0;
        end else begin
            ts_q    <= ts_q + 24'd1;
            trig_p1 <= TRIGGER_IN;
            hist1_q <= hist1_n;
            hist2_q <= hist2_n;
        end
    end

    // History holds the HIT_HIST samples preceding the current cycle, so a
    // discriminator pulse that arrived before the coincidence decision is
    // still attributed to the trigger.
    if (HIT_HIST == 1) begin : g_hist_single
        assign hist1_n = SIGNAL1;
        assign hist2_n = SIGNAL2;
    end else begin : g_hist_shift
        assign hist1_n = {hist1_q[HIT_HIST-2:0], SIGNAL1};
        assign hist2_n = {hist2_q[HIT_HIST-2:0], SIGNAL2};
    end

    assign hit1     = |hist1_q;
    assign hit2     = |hist2_q;
    assign edge_det = TRIGGER_IN && !trig_p1;

`ifdef TRIGGER_RECORDER_DEADTIME_EN
    // Hold-off counter: loaded on every capture, including dropped ones, so
    // the trigger rate seen by the FIFO is bounded regardless of occupancy.
    logic [7:0] holdoff_q;

    assign capture = edge_det && (holdoff_q == 8'd0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            holdoff_q <= 8'd0;
        end else if (capture) begin
            holdoff_q <= 8'(DEADTIME);
        end else if (holdoff_q != 8'd0) begin
            holdoff_q <= holdoff_q - 8'd1;
        end
    end
`else
    assign capture = edge_det;
`endif

    // Fullness is judged on the start-of-cycle count, so a simultaneous pop
    // does not make room for this cycle's push.
    assign push   = capture && (count_q != FULL_CNT);
    assign drop   = capture && (count_q == FULL_CNT);
    assign rec_in = {hit2, hit1, lost_q, ts_q};

    // ---- stage p1: FIFO write, occupancy, loss bookkeeping -----------------
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= rec_in;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lost_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (drop) begin
                lost_q <= (lost_q == 6'd63) ? 6'd63 : lost_q + 6'd1;
            end else if (push) begin
                lost_q <= '0;
            end
            // A drop in the same cycle as CLEAR_OVF keeps the flag set.
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (CLEAR_OVF) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // ---- readout FSM: next state and registered outputs --------------------
    always_comb begin
        state_n    = state_q;
        rec_n      = rec_q;
        rd_data_n  = RD_DATA;
        rd_valid_n = 1'b0;
        pop        = 1'b0;
        byte0_sent = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (RD_REQ && (count_q != '0)) begin
                    pop        = 1'b1;
                    rec_n      = mem[rd_ptr];
                    rd_data_n  = mem[rd_ptr][31:24];
                    rd_valid_n = 1'b1;
                    state_n    = S_B2;
                end
            end
            S_B3: begin
                if (RD_REQ) begin
                    rd_data_n  = rec_q[31:24];
                    rd_valid_n = 1'b1;
                    state_n    = S_B2;
                end
            end
            S_B2: begin
                if (RD_REQ) begin
                    rd_data_n  = rec_q[23:16];
                    rd_valid_n = 1'b1;
                    state_n    = S_B1;
                end
            end
            S_B1: begin
                if (RD_REQ) begin
                    rd_data_n  = rec_q[15:8];
                    rd_valid_n = 1'b1;
                    state_n    = S_B0;
                end
            end
            S_B0: begin
                if (RD_REQ) begin
                    rd_data_n  = rec_q[7:0];
                    rd_valid_n = 1'b1;
                    byte0_sent = 1'b1;
                    state_n    = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // read_mode stays up through the cycle that presents byte 0, even
        // though the FSM is already back in IDLE by then.
        read_mode_n = (state_n != S_IDLE) || byte0_sent;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            RD_DATA   <= 8'h00;
            RD_VALID  <= 1'b0;
            read_mode <= 1'b0;
        end else begin
            state_q   <= state_n;
            RD_DATA   <= rd_data_n;
            RD_VALID  <= rd_valid_n;
            read_mode <= read_mode_n;
        end
    end

    // Popped record is pure data; only the FSM state says whether it is live.
    always_ff @(posedge CLK) begin
        rec_q <= rec_n;
    end

    assign EVENT_COUNT = count_q;
    assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_trigger_event_recorder.sv
module tb_trigger_event_recorder;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       TRIGGER_IN = 1'b0;
    logic       SIGNAL1 = 1'b0;
    logic       SIGNAL2 = 1'b0;
    logic       RD_REQ = 1'b0;
    logic       CLEAR_OVF = 1'b0;
    logic [7:0] RD_DATA;
    logic       RD_VALID;
    logic       read_mode;
    logic [4:0] EVENT_COUNT;
    logic       OVERFLOW;

    int n_vec = 0;
    int n_err = 0;
    int tcount = 0;

`ifdef TRIGGER_RECORDER_DEADTIME_EN
    localparam logic [4:0] PAIR_CNT = 5'd1;
`else
    localparam logic [4:0] PAIR_CNT = 5'd2;
`endif

    trigger_event_recorder #(
        .DEPTH_LOG2(4),
        .DEADTIME  (16),
        .HIT_HIST  (8)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .TRIGGER_IN (TRIGGER_IN),
        .SIGNAL1    (SIGNAL1),
        .SIGNAL2    (SIGNAL2),
        .RD_REQ     (RD_REQ),
        .CLEAR_OVF  (CLEAR_OVF),
        .RD_DATA    (RD_DATA),
        .RD_VALID   (RD_VALID),
        .read_mode  (read_mode),
        .EVENT_COUNT(EVENT_COUNT),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         idle;
        logic [3:0] in;
        logic [7:0] data;
        logic       vld;
        logic       rm;
        logic [4:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input int idle, input logic [3:0] in, input logic [7:0] data,
                                input logic vld, input logic rm, input logic [4:0] cnt,
                                input logic ovf);
        vec_t v;
        v.idle = idle;
        v.in   = in;
        v.data = data;
        v.vld  = vld;
        v.rm   = rm;
        v.cnt  = cnt;
        v.ovf  = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample at the next one.
    task automatic cyc(input logic trig, input logic s1, input logic s2,
                       input logic req, input logic clr);
        TRIGGER_IN = trig;
        SIGNAL1    = s1;
        SIGNAL2    = s2;
        RD_REQ     = req;
        CLEAR_OVF  = clr;
        @(posedge CLK);
        @(negedge CLK);
        tcount++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        TRIGGER_IN = 1'b0;
        SIGNAL1 = 1'b0;
        SIGNAL2 = 1'b0;
        RD_REQ = 1'b0;
        CLEAR_OVF = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        tcount = 0;
    endtask

    task automatic rd_event(input string name, input logic [31:0] exp);
        logic [31:0] e;
        e = exp;
        for (int b = 3; b >= 0; b--) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("%s byte%0d", name, b), RD_DATA, e[b*8 +: 8]);
            chk($sformatf("%s valid%0d", name, b), RD_VALID, 1'b1);
        end
    endtask

    int          exp_ts[16];
    int          t_new;
    int          t_last;
    logic [31:0] rec;

    initial begin
        // in = {trig, sig1, sig2, rd_req}
        tbl[0]  = mk(97, 4'b0100, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[1]  = mk(2,  4'b1000, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0);
        tbl[2]  = mk(0,  4'b0000, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0);
        tbl[3]  = mk(0,  4'b0001, 8'h40, 1'b1, 1'b1, 5'd0, 1'b0);
        tbl[4]  = mk(0,  4'b0001, 8'h00, 1'b1, 1'b1, 5'd0, 1'b0);
        tbl[5]  = mk(0,  4'b0001, 8'h00, 1'b1, 1'b1, 5'd0, 1'b0);
        tbl[6]  = mk(0,  4'b0001, 8'h64, 1'b1, 1'b1, 5'd0, 1'b0);
        tbl[7]  = mk(0,  4'b0000, 8'h64, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[8]  = mk(0,  4'b0001, 8'h64, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[9]  = mk(0,  4'b0000, 8'h64, 1'b0, 1'b0, 5'd0, 1'b0);
        tbl[10] = mk(20, 4'b1000, 8'h64, 1'b0, 1'b0, 5'd1, 1'b0);
        tbl[11] = mk(4,  4'b1000, 8'h64, 1'b0, 1'b0, PAIR_CNT, 1'b0);
        tbl[12] = mk(0,  4'b0000, 8'h64, 1'b0, 1'b0, PAIR_CNT, 1'b0);

        // Reset values, sampled while reset is held.
        repeat (2) @(negedge CLK);
        chk("reset rd_data", RD_DATA, 8'h00);
        chk("reset rd_valid", RD_VALID, 1'b0);
        chk("reset read_mode", read_mode, 1'b0);
        chk("reset event_count", EVENT_COUNT, 5'd0);
        chk("reset overflow", OVERFLOW, 1'b0);
        RESET = 1'b0;
        tcount = 0;

        // Table: capture at ts 0x64, readout, empty read, hold-off pair.
        foreach (tbl[i]) begin
            idle(tbl[i].idle);
            cyc(tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0], 1'b0);
            chk($sformatf("v%0d rd_data", i), RD_DATA, tbl[i].data);
            chk($sformatf("v%0d rd_valid", i), RD_VALID, tbl[i].vld);
            chk($sformatf("v%0d read_mode", i), read_mode, tbl[i].rm);
            chk($sformatf("v%0d event_count", i), EVENT_COUNT, tbl[i].cnt);
            chk($sformatf("v%0d overflow", i), OVERFLOW, tbl[i].ovf);
        end

        // Fill the FIFO, then three drops.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            exp_ts[i] = tcount;
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            idle(19);
        end
        chk("fill count", EVENT_COUNT, 5'd16);
        chk("fill overflow", OVERFLOW, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            idle(19);
        end
        chk("drop count", EVENT_COUNT, 5'd16);
        chk("drop overflow", OVERFLOW, 1'b1);

        rd_event("ovf rec0", {8'h00, 24'(exp_ts[0])});
        chk("after pop count", EVENT_COUNT, 5'd15);

        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        t_new = tcount;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("refill count", EVENT_COUNT, 5'd16);

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("clear overflow", OVERFLOW, 1'b0);

        for (int i = 1; i < 16; i++) begin
            rd_event($sformatf("ovf rec%0d", i), {8'h00, 24'(exp_ts[i])});
        end
        rd_event("lost rec", {8'hC3, 24'(t_new)});
        idle(1);
        chk("drained count", EVENT_COUNT, 5'd0);
        chk("drained read_mode", read_mode, 1'b0);

        // The next record after a lossy one carries lost = 0 again.
        idle(20);
        t_last = tcount;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        rd_event("cleared lost", {8'h00, 24'(t_last)});

        // Timestamp wrap: preload the counter just before the rollover.
        do_reset();
        idle(2);
        force dut.ts_q = 24'hFFFFFF;
        #1;
        release dut.ts_q;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(19);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("wrap count", EVENT_COUNT, 5'd2);
        rd_event("wrap rec0", 32'h00FF_FFFF);
        rd_event("wrap rec1", 32'h0000_0013);

        // Reset in the middle of a readout.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(19);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("pre-abort count", EVENT_COUNT, 5'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre-abort read_mode", read_mode, 1'b1);
        chk("pre-abort count after pop", EVENT_COUNT, 5'd1);
        #2;
        RESET = 1'b1;
        #1;
        chk("abort read_mode", read_mode, 1'b0);
        chk("abort event_count", EVENT_COUNT, 5'd0);
        chk("abort rd_valid", RD_VALID, 1'b0);
        @(negedge CLK);
        RESET = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("post-abort rd_valid", RD_VALID, 1'b0);
        chk("post-abort read_mode", read_mode, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
